// File: rtl/lsu_split.sv
// lsu_split -- load/store unit with a handshaked, word-aligned memory port.
//
// Accepts one load or store from the core. It issues one bus beat, or two
// beats when the access crosses an NB-byte word boundary. It returns
// sign/zero-extended load data with a one-cycle completion pulse.
//
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   req_valid/req_ready               core request handshake
//   req_we, req_funct3, req_addr,
//   req_wdata                         request fields (RISC-V funct3 sizing)
//   resp_valid, resp_rdata, resp_err  completion pulse, load data, error flag
//   bus_req_valid/bus_req_ready       bus beat handshake
//   bus_we, bus_addr, bus_be,
//   bus_wdata                         beat attributes (addr NB-aligned)
//   bus_rsp_valid, bus_rsp_rdata,
//   bus_rsp_err                       one response per accepted beat
module lsu_split #(
    parameter int XLEN           = 32,
    parameter int ADDR_W         = 32,
    parameter bit MISALIGN_SPLIT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [XLEN/8-1:0] bus_be,
    output logic [XLEN-1:0]   bus_wdata,
    input  logic              bus_rsp_valid,
    input  logic [XLEN-1:0]   bus_rsp_rdata,
    input  logic              bus_rsp_err
);
    localparam int NB   = XLEN / 8;
    localparam int OB   = $clog2(NB);
    localparam int SW   = OB + 2;        // wide enough for off + size
    localparam bit IS32 = (XLEN == 32);

    typedef enum logic [2:0] {IDLE, ERR, REQ0, WAIT0, REQ1, WAIT1, DONE} state_t;

    state_t            state_reg, state_next;
    logic              we_reg;
    logic [2:0]        funct3_reg;
    logic [ADDR_W-1:0] base_reg;
    logic [OB-1:0]     off_reg;
    logic              cross_reg;
    logic [XLEN-1:0]   wdata_reg;
    logic [XLEN-1:0]   lo_reg;
    logic [XLEN-1:0]   result_reg;
    logic              err_reg;

    // Request decode
    logic [OB-1:0] req_off;
    logic [SW-1:0] req_span;
    logic          req_cross;
    logic          req_illegal;
    logic          req_fire;

    assign req_off     = req_addr[OB-1:0];
    assign req_span    = SW'(req_off) + (SW'(1) << req_funct3[1:0]);
    assign req_cross   = req_span > SW'(NB);
    assign req_illegal = (req_funct3 == 3'b111)
                       || (req_we && req_funct3[2])
                       || (IS32 && (req_funct3[1:0] == 2'b11))
                       || (IS32 && !req_we && (req_funct3 == 3'b110));
    assign req_fire    = req_valid && (state_reg == IDLE);

    // Byte mask of the access size, LSB-justified
    logic [NB-1:0]   size_be;
    logic [XLEN-1:0] data_mask;

    always_comb begin
        size_be = '0;
        case (funct3_reg[1:0])
            2'd0:    size_be = NB'(1);
            2'd1:    size_be = NB'(3);
            2'd2:    size_be = NB'(15);
            default: size_be = '1;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_mask
            assign data_mask[8*gi +: 8] = {8{size_be[gi]}};
        end
    endgenerate

    // Shifting into a double-width window yields both beats at once:
    // the low half is beat 0 and the high half is the spill into beat 1.
    logic [2*NB-1:0]   be_wide;
    logic [2*XLEN-1:0] wdata_wide;

    assign be_wide    = (2*NB)'(size_be) << off_reg;
    assign wdata_wide = (2*XLEN)'(wdata_reg & data_mask) << {off_reg, 3'b000};

    // Load assembly: beat 0 lands in the low half, beat 1 in the high half.
    // Shift right by the offset to LSB-justify the access.
    logic [2*XLEN-1:0] rd_wide;
    logic [XLEN-1:0]   rd_raw;
    logic [XLEN-1:0]   rd_ext;
    logic              rd_sign;

    assign rd_wide = (state_reg == WAIT1) ? {bus_rsp_rdata, lo_reg}
                                          : {{XLEN{1'b0}}, bus_rsp_rdata};
    assign rd_raw  = XLEN'(rd_wide >> {off_reg, 3'b000});

    always_comb begin
        rd_sign = 1'b0;
        case (funct3_reg[1:0])
            2'd0:    rd_sign = rd_raw[7];
            2'd1:    rd_sign = rd_raw[15];
            2'd2:    rd_sign = rd_raw[31];
            default: rd_sign = rd_raw[XLEN-1];
        endcase
    end

    assign rd_ext = (rd_raw & data_mask)
                  | ((rd_sign && !funct3_reg[2]) ? ~data_mask : '0);

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (req_valid) begin
                if (req_illegal || (req_cross && !MISALIGN_SPLIT))
                    state_next = ERR;
                else
                    state_next = REQ0;
            end
            ERR:   state_next = IDLE;
            REQ0:  if (bus_req_ready) state_next = WAIT0;
            WAIT0: if (bus_rsp_valid) begin
                if (bus_rsp_err || !cross_reg)
                    state_next = DONE;
                else
                    state_next = REQ1;
            end
            REQ1:  if (bus_req_ready) state_next = WAIT1;
            WAIT1: if (bus_rsp_valid) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            we_reg     <= 1'b0;
            funct3_reg <= 3'b000;
            base_reg   <= '0;
            off_reg    <= '0;
            cross_reg  <= 1'b0;
            wdata_reg  <= '0;
            lo_reg     <= '0;
            result_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (req_fire) begin
                we_reg     <= req_we;
                funct3_reg <= req_funct3;
                base_reg   <= {req_addr[ADDR_W-1:OB], {OB{1'b0}}};
                off_reg    <= req_off;
                cross_reg  <= req_cross;
                wdata_reg  <= req_wdata;
                result_reg <= '0;
                err_reg    <= 1'b0;
            end
            // An intermediate beat-0 result is overwritten by the beat-1 merge
            if (((state_reg == WAIT0) || (state_reg == WAIT1)) && bus_rsp_valid) begin
                lo_reg     <= bus_rsp_rdata;
                err_reg    <= bus_rsp_err;
                result_reg <= (we_reg || bus_rsp_err) ? '0 : rd_ext;
            end
        end
    end

    // Outputs are decoded from state, so reset forces them all idle
    always_comb begin
        req_ready     = (state_reg == IDLE);
        resp_valid    = (state_reg == ERR) || (state_reg == DONE);
        resp_err      = (state_reg == ERR) || ((state_reg == DONE) && err_reg);
        resp_rdata    = (state_reg == DONE) ? result_reg : '0;
        bus_req_valid = 1'b0;
        bus_we        = 1'b0;
        bus_addr      = '0;
        bus_be        = '0;
        bus_wdata     = '0;
        if (state_reg == REQ0) begin
            bus_req_valid = 1'b1;
            bus_we        = we_reg;
            bus_addr      = base_reg;
            bus_be        = be_wide[NB-1:0];
            bus_wdata     = we_reg ? wdata_wide[XLEN-1:0] : '0;
        end else if (state_reg == REQ1) begin
            bus_req_valid = 1'b1;
            bus_we        = we_reg;
            bus_addr      = base_reg + ADDR_W'(NB);
            bus_be        = be_wide[2*NB-1:NB];
            bus_wdata     = we_reg ? wdata_wide[2*XLEN-1:XLEN] : '0;
        end
    end
endmodule

// File: tb/tb_lsu_split.sv
// tb_lsu_split -- scoreboard bench for lsu_split (XLEN=32).
// The main instance is split-enabled. A second instance has split disabled
// and is used only for the crossing-error case.
module tb_lsu_split;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        bus_req_valid, bus_req_ready, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_rsp_valid, bus_rsp_err;
    logic [31:0] bus_rsp_rdata;

    logic        req_valid_ns, req_ready_ns, resp_valid_ns, resp_err_ns;
    logic [31:0] resp_rdata_ns;
    logic        bus_req_valid_ns, bus_we_ns;
    logic [31:0] bus_addr_ns, bus_wdata_ns;
    logic [3:0]  bus_be_ns;
    logic        ns_ready = 1'b1;
    logic        ns_rsp_valid = 1'b0;
    logic        ns_rsp_err = 1'b0;
    logic [31:0] ns_rsp_rdata = 32'h0;

    lsu_split #(.XLEN(32), .ADDR_W(32), .MISALIGN_SPLIT(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_rsp_valid(bus_rsp_valid),
        .bus_rsp_rdata(bus_rsp_rdata), .bus_rsp_err(bus_rsp_err)
    );

    lsu_split #(.XLEN(32), .ADDR_W(32), .MISALIGN_SPLIT(1'b0)) u_ns (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_ns), .req_ready(req_ready_ns), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid_ns), .resp_rdata(resp_rdata_ns), .resp_err(resp_err_ns),
        .bus_req_valid(bus_req_valid_ns), .bus_req_ready(ns_ready),
        .bus_we(bus_we_ns), .bus_addr(bus_addr_ns), .bus_be(bus_be_ns),
        .bus_wdata(bus_wdata_ns), .bus_rsp_valid(ns_rsp_valid),
        .bus_rsp_rdata(ns_rsp_rdata), .bus_rsp_err(ns_rsp_err)
    );

    int total = 0;
    int bad = 0;

    typedef struct { logic [31:0] rdata; logic err; int t; } resp_t;
    typedef struct { logic [31:0] addr; logic [3:0] be; logic we; logic [31:0] wdata; } beat_t;

    resp_t       sb_q[$];
    beat_t       beat_q[$];
    logic [31:0] rd_q[$];
    logic        rerr_q[$];
    int          stall_left = 0;
    int          rsp_delay = 0;
    bit          ns_bus_seen = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor: pops the scoreboard whenever a completion appears
    always @(negedge clk) begin : resp_mon
        resp_t e;
        if (!rst && resp_valid) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: got rdata=%h err=%b, required no response", resp_rdata, resp_err);
            end else begin
                e = sb_q.pop_front();
                $display("resp rdata=%h err=%b cycle=%0d", resp_rdata, resp_err, cyc);
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_err", resp_err, e.err);
                if (e.t >= 0) chk("resp_time", cyc, e.t);
            end
        end
    end

    always @(negedge clk) if (bus_req_valid_ns) ns_bus_seen = 1'b1;

    // Bus model: checks every presented beat (also while stalled),
    // answers each accepted beat after rsp_delay extra cycles.
    initial begin : bus_model
        bit acc;
        bus_req_ready = 1'b1;
        bus_rsp_valid = 1'b0;
        bus_rsp_rdata = 32'h0;
        bus_rsp_err   = 1'b0;
        forever begin
            @(negedge clk);
            acc = 1'b0;
            if (!rst && bus_req_valid) begin
                if (beat_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got addr=%h be=%b, required no beat", bus_addr, bus_be);
                end else begin
                    chk("beat_addr", bus_addr, beat_q[0].addr);
                    chk("beat_be", bus_be, beat_q[0].be);
                    chk("beat_we", bus_we, beat_q[0].we);
                    chk("beat_wdata", bus_wdata, beat_q[0].wdata);
                    if (bus_req_ready) begin
                        acc = 1'b1;
                        beat_q.delete(0);
                    end else if (stall_left > 0) begin
                        stall_left--;
                    end
                end
            end
            @(posedge clk);
            #1;
            bus_rsp_valid = 1'b0;
            bus_rsp_rdata = 32'h0;
            bus_rsp_err   = 1'b0;
            bus_req_ready = (stall_left == 0);
            if (acc) begin
                repeat (rsp_delay) begin
                    @(posedge clk);
                    #1;
                end
                bus_rsp_valid = 1'b1;
                bus_rsp_rdata = (rd_q.size() != 0) ? rd_q.pop_front() : 32'h0;
                bus_rsp_err   = (rerr_q.size() != 0) ? rerr_q.pop_front() : 1'b0;
            end
        end
    end

    task automatic beat(input logic [31:0] a, input logic [3:0] be, input logic we,
                        input logic [31:0] wd, input logic [31:0] rd, input logic e);
        beat_t b;
        b.addr = a; b.be = be; b.we = we; b.wdata = wd;
        beat_q.push_back(b);
        rd_q.push_back(rd);
        rerr_q.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb_q.size() != 0 || beat_q.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (sb_q.size() != 0 || beat_q.size() != 0) begin
            bad++;
            $display("FAIL timeout: got %0d responses and %0d beats outstanding, required 0",
                     sb_q.size(), beat_q.size());
            sb_q.delete();
            beat_q.delete();
            rd_q.delete();
            rerr_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Issue one request on the main instance; lat < 0 skips the timing check
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] exp_rd,
                         input logic exp_err, input int lat);
        resp_t r;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        r.rdata = exp_rd;
        r.err   = exp_err;
        r.t     = (lat < 0) ? -1 : cyc + lat;
        sb_q.push_back(r);
        $display("req we=%b f3=%b addr=%h wdata=%h", we, f3, a, wd);
        @(negedge clk);
        chk("req_ready", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_idle();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        rst = 1'b1; req_valid = 1'b0; req_valid_ns = 1'b0; req_we = 1'b0;
        req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_bus_valid", bus_req_valid, 0);
        chk("rst_bus_we", bus_we, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_be", bus_be, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Aligned LW, zero-wait bus
        beat(32'h100, 4'hF, 0, 32'h0, 32'hDEADBEEF, 0);
        issue(0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 3);
        // LB / LBU in top lane
        beat(32'h100, 4'h8, 0, 32'h0, 32'h80112233, 0);
        issue(0, 3'b000, 32'h103, 32'h0, 32'hFFFFFF80, 0, 3);
        beat(32'h100, 4'h8, 0, 32'h0, 32'h80112233, 0);
        issue(0, 3'b100, 32'h103, 32'h0, 32'h00000080, 0, 3);
        // SH upper half; read data on a store response is ignored
        beat(32'h100, 4'hC, 1, 32'hABCD0000, 32'h12345678, 0);
        issue(1, 3'b001, 32'h102, 32'h0000ABCD, 32'h0, 0, 3);
        // SB with garbage above the byte: only the byte reaches the lane
        beat(32'h200, 4'h2, 1, 32'h0000EF00, 32'h0, 0);
        issue(1, 3'b000, 32'h201, 32'h123456EF, 32'h0, 0, 3);
        // Split LW
        beat(32'h0FC, 4'hC, 0, 32'h0, 32'h44332211, 0);
        beat(32'h100, 4'h3, 0, 32'h0, 32'h88776655, 0);
        issue(0, 3'b010, 32'h0FE, 32'h0, 32'h66554433, 0, 5);
        // Split LH, sign-extended across beats
        beat(32'h0FC, 4'h8, 0, 32'h0, 32'h80000000, 0);
        beat(32'h100, 4'h1, 0, 32'h0, 32'h000000FF, 0);
        issue(0, 3'b001, 32'h0FF, 32'h0, 32'hFFFFFF80, 0, 5);
        // Split SW wrapping the address space, 3 stall cycles on beat 0
        stall_left = 3;
        beat(32'hFFFFFFFC, 4'hE, 1, 32'hBBCCDD00, 32'h0, 0);
        beat(32'h00000000, 4'h1, 1, 32'h000000AA, 32'h0, 0);
        issue(1, 3'b010, 32'hFFFFFFFD, 32'hAABBCCDD, 32'h0, 0, 8);
        // Illegal encodings: LD, store with unsigned bit, LWU, funct3 111
        issue(0, 3'b011, 32'h100, 32'h0, 32'h0, 1, 1);
        issue(1, 3'b100, 32'h100, 32'h1, 32'h0, 1, 1);
        issue(0, 3'b110, 32'h100, 32'h0, 32'h0, 1, 1);
        issue(0, 3'b111, 32'h100, 32'h0, 32'h0, 1, 1);
        // Split LW with error on beat 0: no second beat
        beat(32'h0FC, 4'hC, 0, 32'h0, 32'h44332211, 1);
        issue(0, 3'b010, 32'h0FE, 32'h0, 32'h0, 1, 3);

        // Split disabled: crossing LH errors at T+1 with no bus beat
        req_we = 1'b0; req_funct3 = 3'b001; req_addr = 32'h103; req_wdata = 32'h0;
        req_valid_ns = 1'b1;
        $display("req(ns) we=0 f3=001 addr=%h", req_addr);
        @(negedge clk);
        chk("ns_req_ready", req_ready_ns, 1);
        @(posedge clk);
        #1;
        req_valid_ns = 1'b0;
        @(negedge clk);
        chk("ns_resp_valid", resp_valid_ns, 1);
        chk("ns_resp_err", resp_err_ns, 1);
        chk("ns_resp_rdata", resp_rdata_ns, 0);
        @(negedge clk);
        chk("ns_resp_pulse", resp_valid_ns, 0);
        chk("ns_back_idle", req_ready_ns, 1);
        @(posedge clk);
        #1;

        // Reset while waiting for beat 0; its late response must be ignored
        rsp_delay = 2;
        beat(32'h200, 4'hF, 0, 32'h0, 32'h11111111, 0);
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h200; req_valid = 1'b1;
        $display("req we=0 f3=010 addr=%h (reset in WAIT0)", req_addr);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_req_ready", req_ready, 1);
        chk("rst_mid_bus_valid", bus_req_valid, 0);
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid) n++;
        end
        chk("late_rsp_no_resp", n, 0);
        chk("late_rsp_consumed", rd_q.size(), 0);
        rsp_delay = 0;

        chk("ns_bus_never_valid", ns_bus_seen, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
